// File: rtl/dat_buffer_sc_pkg.sv
// Shared definitions for the SD data buffer.
// FIFO_WIDTH is the codebase-wide default data width; it is defined here only
// if the shared defines file has not already provided it.
// blk_ge: block-size comparator shared by the TX-space and RX-ready flags.
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 32
`endif

package dat_buffer_sc_pkg;

  // True when `avail` words cover a block of `need` words. A zero block size
  // never qualifies, so a misprogrammed size cannot start a transfer.
  function automatic logic blk_ge(input logic [31:0] avail, input logic [31:0] need);
    return (need != '0) && (avail >= need);
  endfunction

endpackage

// File: rtl/dat_buffer_sc_fifo.sv
// sync_fifo_ch: single-clock circular FIFO channel, 2**AW words of DW bits.
// Ports:
//   host_clk, rst (async, active-high), clr (sync clear, beats rd/wr)
//   wr/din  : write strobe/data; accepted when not full or a read is accepted too
//   rd/dout : read strobe; dout is registered and holds between reads
//   full, empty, level : registered occupancy status
//   err_ovf : sticky, write dropped while full
//   err_unf : sticky, read issued while empty
module sync_fifo_ch #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          host_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_acc;
  logic          wr_acc;
  logic [AW:0]   level_nxt;

  always_comb begin
    rd_acc    = rd & ~empty;
    // When full, a write is admitted only because the same-edge read frees
    // the slot it overwrites (wr_ptr == rd_ptr); the read sees the old word.
    wr_acc    = wr & (~full | rd_acc);
    level_nxt = level;
    if (wr_acc && !rd_acc)
      level_nxt = level + 1'b1;
    else if (rd_acc && !wr_acc)
      level_nxt = level - 1'b1;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge host_clk) begin
    if (wr_acc && !clr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      dout    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      dout    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      level <= level_nxt;
      // Flags come from the next level so they stay registered.
      full  <= (level_nxt == DEPTH);
      empty <= (level_nxt == '0);
      if (wr && !wr_acc)
        err_ovf <= 1'b1;
      if (rd && empty)
        err_unf <= 1'b1;
    end
  end

endmodule

// File: rtl/dat_buffer_sc.sv
// dat_buffer_sc: SD host data buffer with independent TX (DMA->DAT) and
// RX (DAT->DMA) single-clock FIFO channels.
// Ports:
//   host_clk, rst (async, active-high), blk_words (SD block size in words)
//   tx_* : clr, wr/din (DMA side), rd/dout (DAT side), full, empty, level,
//          blk_space (room for a whole block), ovf (sticky overflow)
//   rx_* : clr, wr/din (DAT side), rd/dout (DMA side), full, empty, level,
//          blk_rdy (a whole block buffered), unf (sticky underflow)
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 32
`endif

module dat_buffer_sc
  import dat_buffer_sc_pkg::*;
#(
  parameter int DW = `FIFO_WIDTH,
  parameter int AW = 4,
  parameter int BW = 10
) (
  input  logic          host_clk,
  input  logic          rst,
  input  logic [BW-1:0] blk_words,
  input  logic          tx_clr,
  input  logic          tx_wr,
  input  logic [DW-1:0] tx_din,
  input  logic          tx_rd,
  output logic [DW-1:0] tx_dout,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [AW:0]   tx_level,
  output logic          tx_blk_space,
  output logic          tx_ovf,
  input  logic          rx_clr,
  input  logic          rx_wr,
  input  logic [DW-1:0] rx_din,
  input  logic          rx_rd,
  output logic [DW-1:0] rx_dout,
  output logic          rx_full,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          rx_blk_rdy,
  output logic          rx_unf
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  // Only overflow matters on TX and only underflow on RX.
  logic        tx_unf_unused;
  logic        rx_ovf_unused;
  logic [AW:0] tx_free;

  sync_fifo_ch #(.DW(DW), .AW(AW)) u_tx (
    .host_clk (host_clk),
    .rst      (rst),
    .clr      (tx_clr),
    .wr       (tx_wr),
    .din      (tx_din),
    .rd       (tx_rd),
    .dout     (tx_dout),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level),
    .err_ovf  (tx_ovf),
    .err_unf  (tx_unf_unused)
  );

  sync_fifo_ch #(.DW(DW), .AW(AW)) u_rx (
    .host_clk (host_clk),
    .rst      (rst),
    .clr      (rx_clr),
    .wr       (rx_wr),
    .din      (rx_din),
    .rd       (rx_rd),
    .dout     (rx_dout),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level),
    .err_ovf  (rx_ovf_unused),
    .err_unf  (rx_unf)
  );

  always_comb begin
    tx_free      = DEPTH - tx_level;
    tx_blk_space = blk_ge(32'(tx_free), 32'(blk_words));
    rx_blk_rdy   = blk_ge(32'(rx_level), 32'(blk_words));
  end

endmodule

// File: tb/tb_dat_buffer_sc.sv
module tb_dat_buffer_sc;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 10;

  logic          host_clk = 1'b0;
  logic          rst;
  logic [BW-1:0] blk_words;
  logic          tx_clr, tx_wr, tx_rd;
  logic [DW-1:0] tx_din, tx_dout;
  logic          tx_full, tx_empty, tx_blk_space, tx_ovf;
  logic [AW:0]   tx_level;
  logic          rx_clr, rx_wr, rx_rd;
  logic [DW-1:0] rx_din, rx_dout;
  logic          rx_full, rx_empty, rx_blk_rdy, rx_unf;
  logic [AW:0]   rx_level;

  dat_buffer_sc #(.DW(DW), .AW(AW), .BW(BW)) dut (
    .host_clk     (host_clk),
    .rst          (rst),
    .blk_words    (blk_words),
    .tx_clr       (tx_clr),
    .tx_wr        (tx_wr),
    .tx_din       (tx_din),
    .tx_rd        (tx_rd),
    .tx_dout      (tx_dout),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_level     (tx_level),
    .tx_blk_space (tx_blk_space),
    .tx_ovf       (tx_ovf),
    .rx_clr       (rx_clr),
    .rx_wr        (rx_wr),
    .rx_din       (rx_din),
    .rx_rd        (rx_rd),
    .rx_dout      (rx_dout),
    .rx_full      (rx_full),
    .rx_empty     (rx_empty),
    .rx_level     (rx_level),
    .rx_blk_rdy   (rx_blk_rdy),
    .rx_unf       (rx_unf)
  );

  always #5 host_clk = ~host_clk;

  int total = 0;
  int bad   = 0;

  // Expected dout after each issued read (including ignored reads, where dout holds).
  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] exp_rx[$];
  logic          tx_chk = 1'b0;
  logic          rx_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read strobe sampled on an edge means dout is due for checking.
  always @(posedge host_clk) begin
    tx_chk <= tx_rd;
    rx_chk <= rx_rd;
  end

  initial begin
    forever begin
      @(negedge host_clk);
      if (tx_chk) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_dout: read with no expected entry at %0t", $time);
        end else chk("tx_dout", 64'(tx_dout), 64'(exp_tx.pop_front()));
      end
      if (rx_chk) begin
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_dout: read with no expected entry at %0t", $time);
        end else chk("rx_dout", 64'(rx_dout), 64'(exp_rx.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge host_clk);
    #1;
  endtask

  task automatic tx_write(input logic [DW-1:0] d);
    tx_wr = 1'b1; tx_din = d; cyc(); tx_wr = 1'b0;
  endtask

  task automatic tx_read(input logic [DW-1:0] e);
    tx_rd = 1'b1; exp_tx.push_back(e); cyc(); tx_rd = 1'b0;
  endtask

  task automatic rx_write(input logic [DW-1:0] d);
    rx_wr = 1'b1; rx_din = d; cyc(); rx_wr = 1'b0;
  endtask

  task automatic rx_read(input logic [DW-1:0] e);
    rx_rd = 1'b1; exp_rx.push_back(e); cyc(); rx_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; blk_words = 10'd1;
    tx_clr = 0; tx_wr = 0; tx_rd = 0; tx_din = '0;
    rx_clr = 0; rx_wr = 0; rx_rd = 0; rx_din = '0;
    #23;
    chk("rst tx_empty", 64'(tx_empty), 1);
    chk("rst tx_full", 64'(tx_full), 0);
    chk("rst tx_level", 64'(tx_level), 0);
    chk("rst rx_empty", 64'(rx_empty), 1);
    chk("rst rx_level", 64'(rx_level), 0);
    chk("rst tx_dout", 64'(tx_dout), 0);
    chk("rst flags", 64'({tx_ovf, rx_unf, rx_blk_rdy}), 0);
    chk("rst tx_blk_space", 64'(tx_blk_space), 1);
    @(negedge host_clk); rst = 1'b0;
    cyc();

    // Fill TX, then overflow
    for (int i = 1; i <= 16; i++) tx_write(DW'(i));
    chk("fill tx_full", 64'(tx_full), 1);
    chk("fill tx_level", 64'(tx_level), 16);
    chk("fill tx_blk_space", 64'(tx_blk_space), 0);
    chk("fill tx_ovf", 64'(tx_ovf), 0);
    tx_write(32'h77);
    chk("ovf tx_ovf", 64'(tx_ovf), 1);
    chk("ovf tx_level", 64'(tx_level), 16);

    // Drain TX in order, then one read while empty holds dout
    for (int i = 1; i <= 16; i++) tx_read(DW'(i));
    chk("drain tx_empty", 64'(tx_empty), 1);
    chk("drain tx_level", 64'(tx_level), 0);
    tx_read(32'h10);
    chk("ovf sticky", 64'(tx_ovf), 1);
    tx_clr = 1'b1; cyc(); tx_clr = 1'b0;
    chk("tx_clr ovf", 64'(tx_ovf), 0);
    chk("tx_clr dout", 64'(tx_dout), 0);

    // RX full with simultaneous write and read
    for (int i = 1; i <= 16; i++) rx_write(DW'(i));
    chk("rx_full", 64'(rx_full), 1);
    rx_wr = 1'b1; rx_din = 32'h99; rx_rd = 1'b1; exp_rx.push_back(32'h1);
    cyc(); rx_wr = 1'b0; rx_rd = 1'b0;
    chk("rdwr full rx_level", 64'(rx_level), 16);
    chk("rdwr full rx_full", 64'(rx_full), 1);
    for (int i = 2; i <= 16; i++) rx_read(DW'(i));
    rx_read(32'h99);
    chk("rx drained empty", 64'(rx_empty), 1);
    chk("rx no unf", 64'(rx_unf), 0);

    // RX empty: read ignored (dout holds 0x99), write accepted, underflow set
    rx_wr = 1'b1; rx_din = 32'hA5; rx_rd = 1'b1; exp_rx.push_back(32'h99);
    cyc(); rx_wr = 1'b0; rx_rd = 1'b0;
    chk("unf rx_unf", 64'(rx_unf), 1);
    chk("unf rx_level", 64'(rx_level), 1);
    chk("unf rx_empty", 64'(rx_empty), 0);
    rx_read(32'hA5);
    chk("unf sticky", 64'(rx_unf), 1);

    // Block thresholds with blk_words = 8
    blk_words = 10'd8;
    for (int i = 0; i < 7; i++) rx_write(DW'(32'h200 + i));
    chk("blk7 rx_blk_rdy", 64'(rx_blk_rdy), 0);
    rx_write(32'h207);
    chk("blk8 rx_blk_rdy", 64'(rx_blk_rdy), 1);
    chk("blk8 rx_level", 64'(rx_level), 8);
    rx_clr = 1'b1; rx_wr = 1'b1; rx_din = 32'h5A; cyc(); rx_clr = 1'b0; rx_wr = 1'b0;
    chk("clr rx_level", 64'(rx_level), 0);
    chk("clr rx_unf", 64'(rx_unf), 0);
    chk("clr rx_blk_rdy", 64'(rx_blk_rdy), 0);
    chk("clr rx_dout", 64'(rx_dout), 0);
    for (int i = 0; i < 8; i++) tx_write(DW'(32'h300 + i));
    chk("tx free8 blk8", 64'(tx_blk_space), 1);
    tx_write(32'h308);
    chk("tx free7 blk8", 64'(tx_blk_space), 0);
    blk_words = 10'd0;
    #1;
    chk("blk0 tx_blk_space", 64'(tx_blk_space), 0);
    chk("blk0 rx_blk_rdy", 64'(rx_blk_rdy), 0);
    blk_words = 10'd1;

    // Async reset mid-burst, between edges
    tx_wr = 1'b1; tx_din = 32'h400;
    cyc();
    #2; rst = 1'b1; #1;
    tx_wr = 1'b0;
    chk("async tx_level", 64'(tx_level), 0);
    chk("async tx_empty", 64'(tx_empty), 1);
    chk("async tx_full", 64'(tx_full), 0);
    chk("async tx_dout", 64'(tx_dout), 0);
    @(negedge host_clk); rst = 1'b0;
    cyc();

    // 20 streaming writes/reads so both pointers wrap past the end
    tx_write(32'h100);
    for (int i = 1; i < 20; i++) begin
      tx_wr = 1'b1; tx_din = DW'(32'h100 + i);
      tx_rd = 1'b1; exp_tx.push_back(DW'(32'h100 + i - 1));
      cyc();
    end
    tx_wr = 1'b0; tx_rd = 1'b0;
    chk("wrap tx_level", 64'(tx_level), 1);
    tx_read(32'h113);
    chk("wrap tx_empty", 64'(tx_empty), 1);

    cyc(); cyc();
    chk("tx queue drained", 64'(exp_tx.size()), 0);
    chk("rx queue drained", 64'(exp_rx.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dat_buffer_sc.md
DAT_BUFFER_SC -- requirements
Module: dat_buffer_sc

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DW, `FIFO_WIDTH (32): data word width
- AW, 4: address width; depth = 2**AW words per channel
- BW, 10: width of block-size input
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- host_clk, in, 1: sole clock
- rst, in, 1: async active-high reset
- blk_words, in, BW: words per SD block (1..2**AW)
- tx_clr, in, 1: sync clear, TX channel
- tx_wr, in, 1: TX write strobe (DMA side)
- tx_din, in, DW: TX write data
- tx_rd, in, 1: TX read strobe (DAT side)
- tx_dout, out, DW: TX read data
- tx_full, out, 1: TX full
- tx_empty, out, 1: TX empty
- tx_level, out, AW+1: TX occupancy
- tx_blk_space, out, 1: TX free words >= blk_words
- tx_ovf, out, 1: sticky TX overflow
- rx_clr, in, 1: sync clear, RX channel
- rx_wr, in, 1: RX write strobe (DAT side)
- rx_din, in, DW: RX write data
- rx_rd, in, 1: RX read strobe (DMA side)
- rx_dout, out, DW: RX read data
- rx_full, out, 1: RX full
- rx_empty, out, 1: RX empty
- rx_level, out, AW+1: RX occupancy
- rx_blk_rdy, out, 1: RX level >= blk_words
- rx_unf, out, 1: sticky RX underflow

Function
REQ-004 Each channel SHALL be an independent single-clock circular FIFO of 2**AW words of DW bits.
REQ-005 Write SHALL be accepted on a rising edge with wr=1 and (not full, or rd accepted in the same cycle).
REQ-006 Read SHALL be accepted on a rising edge with rd=1 and not empty; dout SHALL be registered and present the head word one cycle after acceptance, holding its value otherwise.
REQ-007 Read and write accepted in the same cycle SHALL leave level unchanged; when full, both SHALL be accepted.
REQ-008 rd=1 while empty SHALL be ignored; a write in that same cycle SHALL still be accepted. On RX this SHALL set rx_unf.
REQ-009 wr=1 while full with no accepted read SHALL be dropped, leaving storage unchanged. On TX this SHALL set tx_ovf.
REQ-010 Pointers SHALL be AW bits and wrap modulo 2**AW. level SHALL be AW+1 bits, range 0..2**AW.
REQ-011 full SHALL equal (level == 2**AW) and empty SHALL equal (level == 0); both SHALL be registered with no combinational path from strobes.
REQ-012 rx_blk_rdy SHALL equal (rx_level >= blk_words) and tx_blk_space SHALL equal ((2**AW - tx_level) >= blk_words), both combinational from registered levels; blk_words=0 SHALL force both to 0.
REQ-013 clr SHALL take priority over rd/wr in the same cycle: pointers, level, dout and sticky flag reset to 0 next edge; storage contents are don't-care.
REQ-014 Sticky flags SHALL clear only on rst or their channel's clr.

Reset
REQ-015 rst SHALL asynchronously force all pointers, levels, dout, tx_ovf and rx_unf to 0, with empty=1 and full=0; storage SHALL NOT be reset.
REQ-016 rst asserted mid-transfer SHALL discard all in-flight data; the first accepted write after deassertion SHALL land at address 0.

Structure
REQ-017 DW default and any flag encodings SHALL come from the shared defines file (`FIFO_WIDTH); no new package constants are required.
REQ-018 One sub-module, sync_fifo_ch (parameters DW, AW; ports host_clk, rst, clr, wr, din, rd, dout, full, empty, level, err_ovf, err_unf), SHALL be instantiated twice. The top level SHALL contain only the block comparators and the flag selection.

Verification
REQ-019 Fill TX with 16 writes 0x1..0x10 (AW=4) -> tx_full=1, tx_level=16, tx_blk_space=0 for blk_words=1. A 17th write -> tx_ovf=1, level stays 16.
REQ-020 Read TX 16 times -> tx_dout sequence 0x1..0x10 each one cycle after rd, then tx_empty=1. An extra rd -> tx_dout holds 0x10.
REQ-021 RX full with simultaneous rx_wr=1/rx_rd=1 -> both accepted, rx_level=16, rx_full stays 1, new word readable last.
REQ-022 RX empty with rx_rd=1 and rx_wr=1 same cycle (din=0xA5) -> rx_unf=1, rx_level=1, next read returns 0xA5.
REQ-023 blk_words=8: write 7 RX words -> rx_blk_rdy=0; 8th write -> rx_blk_rdy=1 the cycle after; then rx_clr together with rx_wr -> level 0, rx_unf=0, rx_blk_rdy=0.
REQ-024 rst pulsed asynchronously mid-burst (between edges) -> all outputs at reset values immediately. After release, 20 wrap-around writes/reads return data in order.
